// File: rtl/act_feeder_row_if.sv
// Activation-feeder bus: descriptor load, shared-buffer read port and per-row
// superblock activation-load signals. master = feeder, slave = surroundings.
interface act_feeder_row_if #(
    parameter int N_ROW       = 12,
    parameter int WID_ACT     = 16,
    parameter int WID_BUFADDR = 10,
    parameter int WID_LEN     = 7
);
    localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;

    logic                        cfg_en;
    logic [ROW_W-1:0]            cfg_row;
    logic [WID_BUFADDR-1:0]      cfg_base;
    logic [WID_LEN-1:0]          cfg_len;
    logic                        buf_rd_en;
    logic [WID_BUFADDR-1:0]      buf_rd_addr;
    logic [2*WID_ACT-1:0]        buf_rd_data;
    logic [2*WID_ACT*N_ROW-1:0]  act_data_in;
    logic [N_ROW-1:0]            act_data_in_vld;
    logic [N_ROW-1:0]            act_data_in_req;
    logic [N_ROW-1:0]            row_done;
    logic                        cfg_err;

    modport master (
        input  cfg_en, cfg_row, cfg_base, cfg_len, buf_rd_data, act_data_in_req,
        output buf_rd_en, buf_rd_addr, act_data_in, act_data_in_vld, row_done, cfg_err
    );
    modport slave (
        output cfg_en, cfg_row, cfg_base, cfg_len, buf_rd_data, act_data_in_req,
        input  buf_rd_en, buf_rd_addr, act_data_in, act_data_in_vld, row_done, cfg_err
    );
endinterface

// File: rtl/act_feeder_row.sv
// Activation feeder for one superblock row group: per-row burst descriptors,
// single-port buffer arbitration (round-robin when ACT_FEEDER_RR_EN, else fixed priority).
module act_feeder_row #(
    parameter int N_ROW       = 12,
    parameter int WID_ACT     = 16,
    parameter int WID_ACTADDR = 6,
    parameter int WID_BUFADDR = 10,
    parameter int WID_LEN     = WID_ACTADDR + 1
) (
    input logic              clk_l,
    input logic              rst,
    act_feeder_row_if.master bus
);
    localparam int ROW_W = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int DW    = 2 * WID_ACT;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} row_state_t;

    row_state_t             state_q [N_ROW];
    row_state_t             state_d [N_ROW];
    logic [WID_BUFADDR-1:0] ptr_q   [N_ROW];
    logic [WID_BUFADDR-1:0] ptr_d   [N_ROW];
    logic [WID_LEN-1:0]     rem_q   [N_ROW];
    logic [WID_LEN-1:0]     rem_d   [N_ROW];
    logic [N_ROW-1:0]       done_q, done_d;
    logic                   err_q, err_d;

    logic [N_ROW-1:0]       elig;
    logic                   gnt_vld;
    logic [ROW_W-1:0]       gnt_row;

    logic                   p1_vld;
    logic [ROW_W-1:0]       p1_row;
    logic [DW*N_ROW-1:0]    data_q;
    logic [N_ROW-1:0]       vld_q;

`ifdef ACT_FEEDER_RR_EN
    logic [ROW_W-1:0]       last_q;
    int unsigned            idx;
`endif

    always_comb begin
        gnt_vld = 1'b0;
        gnt_row = '0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            elig[r] = (state_q[r] == ACTIVE) && bus.act_data_in_req[r] && (rem_q[r] != '0);
        end
`ifdef ACT_FEEDER_RR_EN
        idx = 0;
        // Search begins one past the last granted row and wraps around.
        for (int unsigned k = 1; k <= N_ROW; k++) begin
            idx = (32'(last_q) + k) % N_ROW;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_row = ROW_W'(idx);
            end
        end
`else
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (!gnt_vld && elig[r]) begin
                gnt_vld = 1'b1;
                gnt_row = ROW_W'(r);
            end
        end
`endif
    end

    always_ff @(posedge clk_l) begin
        if (rst) begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                state_q[r] <= IDLE;
                ptr_q[r]   <= '0;
                rem_q[r]   <= '0;
            end
            done_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                state_q[r] <= state_d[r];
                ptr_q[r]   <= ptr_d[r];
                rem_q[r]   <= rem_d[r];
            end
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Grant and config never hit the same row: config is only taken outside ACTIVE.
    always_comb begin
        for (int unsigned r = 0; r < N_ROW; r++) begin
            state_d[r] = state_q[r];
            ptr_d[r]   = ptr_q[r];
            rem_d[r]   = rem_q[r];
        end
        done_d = done_q;
        err_d  = err_q;
        if (gnt_vld) begin
            ptr_d[gnt_row] = ptr_q[gnt_row] + 1'b1;
            rem_d[gnt_row] = rem_q[gnt_row] - 1'b1;
            if (rem_q[gnt_row] == WID_LEN'(1)) begin
                state_d[gnt_row] = DONE;
                done_d[gnt_row]  = 1'b1;
            end
        end
        if (bus.cfg_en && (32'(bus.cfg_row) < N_ROW)) begin
            if (state_q[bus.cfg_row] == ACTIVE) begin
                err_d = 1'b1;
            end else begin
                ptr_d[bus.cfg_row]   = bus.cfg_base;
                rem_d[bus.cfg_row]   = bus.cfg_len;
                done_d[bus.cfg_row]  = (bus.cfg_len == '0);
                state_d[bus.cfg_row] = (bus.cfg_len == '0) ? DONE : ACTIVE;
            end
        end
    end

    always_comb begin
        bus.buf_rd_en       = gnt_vld;
        bus.buf_rd_addr     = gnt_vld ? ptr_q[gnt_row] : '0;
        bus.act_data_in     = data_q;
        bus.act_data_in_vld = vld_q;
        bus.row_done        = done_q;
        bus.cfg_err         = err_q;
    end

    // Read pipeline: row tag follows the one-cycle buffer latency.
    always_ff @(posedge clk_l) begin
        if (rst) begin
            p1_vld <= 1'b0;
            p1_row <= '0;
            data_q <= '0;
            vld_q  <= '0;
`ifdef ACT_FEEDER_RR_EN
            last_q <= ROW_W'(N_ROW - 1);
`endif
        end else begin
            p1_vld <= gnt_vld;
            p1_row <= gnt_row;
            vld_q  <= '0;
            if (p1_vld) begin
                vld_q[p1_row]             <= 1'b1;
                data_q[p1_row*DW +: DW]   <= bus.buf_rd_data;
            end
`ifdef ACT_FEEDER_RR_EN
            if (gnt_vld) last_q <= gnt_row;
`endif
        end
    end
endmodule

// File: doc/act_feeder_row.md
# act_feeder_row

Activation feeder for one row group of superblocks. It owns the single read port of the shared activation buffer and answers each superblock's `act_data_in_req` with packed activation words on `act_data_in`/`act_data_in_vld`. It is the transmitting end of the superblock activation-load interface, and sits between the controller/activation buffer and the superblock row.

## Interface
- `N_ROW`, 12: number of superblocks served.
- `WID_ACT`, 16: activation width; one word carries 2 activations.
- `WID_ACTADDR`, 6: superblock activation-buffer address width; max burst length is 2^WID_ACTADDR.
- `WID_BUFADDR`, 10: shared activation buffer address width.
- `WID_LEN`, WID_ACTADDR+1: burst length field width.

Ports:
- `clk_l`  in  1  controller clock. One clock only; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_en`  in  1  load a burst descriptor.
- `cfg_row`  in  $clog2(N_ROW)  target row.
- `cfg_base`  in  WID_BUFADDR  first buffer address.
- `cfg_len`  in  WID_LEN  word count.
- `buf_rd_en`  out  1  buffer read strobe.
- `buf_rd_addr`  out  WID_BUFADDR  read address.
- `buf_rd_data`  in  2*WID_ACT  read data, valid 1 cycle after `buf_rd_en`.
- `act_data_in`  out  2*WID_ACT*N_ROW  per-row data, row r at [r*2*WID_ACT +: 2*WID_ACT].
- `act_data_in_vld`  out  N_ROW  per-row one-cycle data strobe.
- `act_data_in_req`  in  N_ROW  per-row level request from the superblock.
- `row_done`  out  N_ROW  sticky "burst complete" flag per row.
- `cfg_err`  out  1  sticky flag: descriptor was rejected.

## Operation
- Each row keeps a state (IDLE, ACTIVE, DONE), a pointer `ptr[r]` and a remaining count `rem[r]`.
- **IDLE/DONE + `cfg_en` for row r:**
  - Load `ptr=cfg_base` and `rem=cfg_len`.
  - Clear `row_done[r]`.
  - Go to ACTIVE. If `cfg_len==0`, go straight to DONE and set `row_done[r]`.
- **ACTIVE + `cfg_en` for row r:** the descriptor is ignored and `cfg_err` is set. `cfg_err` clears only on `rst`.
- **Eligibility:** row r is eligible when it is ACTIVE, `act_data_in_req[r]=1` and `rem[r]!=0`.
- **Grant:** at most one grant per cycle.
  - Grant issues `buf_rd_en=1` with `buf_rd_addr=ptr[g]`.
  - At the edge, `ptr[g]` increments (wrapping modulo 2^WID_BUFADDR) and `rem[g]` decrements.
  - When `rem[g]` reaches 0, the row goes to DONE and `row_done[g]` is set.
- **Pipeline:** the granted row index is carried one stage alongside the buffer latency. `buf_rd_data` is registered into that row's `act_data_in` slice with `act_data_in_vld[g]` high for exactly one cycle.
- **Data hold:** the other rows' `act_data_in` slices hold their last value. `act_data_in_vld` is never high for two rows in the same cycle.
- **Request withdrawal:** a superblock may drop its request at any time. Up to 2 already-granted words per row may still arrive after the drop, and the superblock must accept them.
- **Concurrency:** configuring one row does not stall grants to the other rows.

## Timing
- **Reset:** all rows IDLE, `ptr`/`rem` = 0. `buf_rd_en`, `buf_rd_addr`, `act_data_in`, `act_data_in_vld`, `row_done`, `cfg_err` are all 0. In-flight reads are discarded and no vld is emitted after `rst`.
- **Request-to-data latency:** request seen (combinational) in cycle t → grant and `buf_rd_en` in cycle t → data registered at the end of t+1 → `act_data_in_vld` high in cycle t+2.
- **Throughput:** 1 word per cycle aggregate. A single requesting row with no competitors receives a word every cycle.
- **Config latency:** a descriptor loaded in cycle t makes the row eligible in cycle t+1.
- **DONE timing:** `row_done[r]` rises the cycle after the last grant, before that last word's vld (which arrives 1 cycle later).
- **Simultaneous `cfg_en` and grant:** these cannot target the same row, because configuration is only accepted outside ACTIVE.

## Configuration
- `ACT_FEEDER_RR_EN` defined: round-robin arbitration. The search starts at the row after the last granted row, and the pointer advances only on a grant.
- `ACT_FEEDER_RR_EN` undefined: fixed priority, lowest eligible row index wins. Starvation is then possible and accepted.

## Test plan
- **Reset/single burst:** `rst` mid-burst → all outputs 0 next cycle and no stray vld. Then cfg row 3, base=0x3FE, len=4, req[3] held high → reads 0x3FE, 0x3FF, 0x000, 0x001 (wrap), four back-to-back vld[3] starting 2 cycles after the first grant, `row_done[3]` set.
- **Zero length:** cfg row 0 with len=0 → `row_done[0]` next cycle, no `buf_rd_en`.
- **Contention:** rows 1, 2, 5 ACTIVE with len=3 each, all requesting.
  - With `ACT_FEEDER_RR_EN`: grant order 1,2,5,1,2,5,1,2,5.
  - Without it: order 1,1,1,2,2,2,5,5,5.
- **Withdrawal:** req[4] dropped for 5 cycles mid-burst → at most 2 vld[4] after the drop, none further. On re-assertion the burst resumes with the correct next address and the total word count equals len.
- **Rejected config:** cfg while row ACTIVE → `cfg_err`=1, `ptr`/`rem` unchanged, burst completes normally.
- **Scoreboard:** random req patterns on 12 rows → per-row data sequence equals the buffer model contents from base, never two vld bits in one cycle.
